dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller.
- Responds to the CPU pipeline's MEM-stage load/store port and hides a multi-cycle main memory behind a stall signal.
- Holds the tag, valid, dirty and data arrays internally in registers.
- Issues line writebacks and line fills to main memory over a req/rdy handshake.

---
 rtl/dcache_ctrl_if.sv | 27 ++
 rtl/dcache_ctrl.sv | 127 ++++++++++++
 tb/tb_dcache_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU load/store port and main-memory line port of the data cache controller.
interface dcache_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        stall;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;

  // controller side: serves the CPU, masters the memory transaction
  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
    output cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

  // environment side: pipeline plus main memory
  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
    input  cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//
//   state  | meaning
//   IDLE   | serving hits; a miss starts a writeback or a fill
//   WRBACK | dirty victim line being written to memory (mem_we held)
//   ALLOC  | requested line being fetched from memory (mem_re held)
module dcache_ctrl #(
  parameter  int INDEX_BITS = 3,
  localparam int TAG_BITS   = 16 - 2 - INDEX_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_ctrl_if.slave  bus,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRBACK, ALLOC} state_t;

  state_t                state_q;
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [63:0]           data_q [LINES];

  logic                  mem_re_q;
  logic                  mem_we_q;
  logic [13:0]           mem_addr_q;
  logic [63:0]           mem_wdata_q;
  logic [15:0]           hit_cnt_q;
  logic [15:0]           miss_cnt_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic [1:0]            word;
  logic                  req;
  logic                  is_store;
  logic                  hit;

  assign idx      = bus.cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag  = bus.cpu_addr[15:INDEX_BITS+2];
  assign word     = bus.cpu_addr[1:0];
  assign req      = bus.cpu_re | bus.cpu_we;
  assign is_store = bus.cpu_we;
  assign hit      = valid_q[idx] && (tag_q[idx] == cpu_tag);

  // stall until the request can complete in IDLE as a hit
  assign bus.stall     = req && ((state_q != IDLE) || !hit);
  // invalid lines read as zero so stale array contents never leak out
  assign bus.cpu_rdata = valid_q[idx] ? data_q[idx][{word, 4'b0000} +: 16] : 16'h0000;

  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

  // control FSM: line state bits, registered memory request, statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
              if (is_store) dirty_q[idx] <= 1'b1;
            end else begin
              if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
              if (valid_q[idx] && dirty_q[idx]) begin
                state_q     <= WRBACK;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= {tag_q[idx], idx};
                mem_wdata_q <= data_q[idx];
              end else begin
                state_q    <= ALLOC;
                mem_re_q   <= 1'b1;
                mem_addr_q <= bus.cpu_addr[15:2];
              end
            end
          end
        end
        WRBACK: begin
          if (bus.mem_rdy) begin
            dirty_q[idx] <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b1;
            mem_addr_q   <= bus.cpu_addr[15:2];
            state_q      <= ALLOC;
          end
        end
        ALLOC: begin
          if (bus.mem_rdy) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            mem_re_q     <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // tag and data arrays: fill on completed allocation, word write on store hit
  always_ff @(posedge clk) begin
    if (state_q == ALLOC && bus.mem_rdy) begin
      data_q[idx] <= bus.mem_rdata;
      tag_q[idx]  <= cpu_tag;
    end else if (state_q == IDLE && req && hit && is_store) begin
      data_q[idx][{word, 4'b0000} +: 16] <= bus.cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then random traffic
// against a line-level cache/memory reference model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  dcache_ctrl_if bus();

  dcache_ctrl #(.INDEX_BITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: cache contents plus a sparse main memory
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [10:0] m_tag   [8];
  logic [63:0] m_line  [8];
  logic [63:0] main_mem [logic [13:0]];
  logic [15:0] exp_hit;
  logic [15:0] exp_miss;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_get(input logic [13:0] a);
    if (main_mem.exists(a)) return main_mem[a];
    return {2'b10, a, 2'b01, ~a, a[13:0] ^ 14'h25C3, 2'b11, 2'b00, a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hit  = 16'd0;
    exp_miss = 16'd0;
  endtask

  // Issue one request starting just after a rising edge and serve memory
  // until the pipeline is released; returns just after the completing edge.
  task automatic do_req(input logic [15:0] addr, input bit st, input logic [15:0] wd,
                        input int lat_wb_in, input int lat_fill_in,
                        output logic [15:0] rd, output bit saw_wb);
    logic [2:0]  idx;
    logic [10:0] tg;
    int          w;
    bit          hit_e, wb_e, saw_fill, done;
    logic [13:0] vic_a;
    logic [63:0] vic_d;
    int          lat_wb, lat_fill, n_wb, n_fill, stalled, exp_stall;

    idx   = addr[4:2];
    tg    = addr[15:5];
    w     = int'(addr[1:0]);
    hit_e = m_valid[idx] && (m_tag[idx] == tg);
    wb_e  = !hit_e && m_valid[idx] && m_dirty[idx];
    vic_a = {m_tag[idx], idx};
    vic_d = m_line[idx];
    lat_wb   = (lat_wb_in   == 0) ? int'($urandom_range(1, 4)) : lat_wb_in;
    lat_fill = (lat_fill_in == 0) ? int'($urandom_range(1, 4)) : lat_fill_in;

    bus.cpu_addr  = addr;
    bus.cpu_we    = st;
    bus.cpu_re    = st ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.cpu_wdata = wd;

    n_wb = 0; n_fill = 0; stalled = 0; done = 0; saw_wb = 0; saw_fill = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      bus.mem_rdy = 1'b0;
      check_val("mem_excl", {63'd0, bus.mem_re & bus.mem_we}, 64'd0);
      if (!bus.stall) begin
        done = 1;
        check_val("idle_mem", {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
      end else begin
        stalled++;
        if (bus.mem_we) begin
          saw_wb = 1;
          n_wb++;
          check_val("wb_addr", {50'd0, bus.mem_addr}, {50'd0, vic_a});
          check_val("wb_data", bus.mem_wdata, vic_d);
          if (n_wb == lat_wb) bus.mem_rdy = 1'b1;
        end else if (bus.mem_re) begin
          saw_fill = 1;
          n_fill++;
          check_val("fill_addr", {50'd0, bus.mem_addr}, {50'd0, addr[15:2]});
          bus.mem_rdata = mem_get(addr[15:2]);
          if (n_fill == lat_fill) bus.mem_rdy = 1'b1;
        end
      end
    end
    if (!done) check_val("timeout", 64'd0, 64'd1);
    rd = bus.cpu_rdata;

    exp_stall = hit_e ? 0 : (1 + (wb_e ? lat_wb : 0) + lat_fill);
    check_val("stall_cycles", 64'(stalled), 64'(exp_stall));
    check_val("saw_wb",   {63'd0, saw_wb},   {63'd0, wb_e});
    check_val("saw_fill", {63'd0, saw_fill}, {63'd0, !hit_e});

    if (!hit_e) begin
      if (exp_miss != 16'hFFFF) exp_miss++;
      if (wb_e) main_mem[vic_a] = vic_d;
      m_line[idx]  = mem_get(addr[15:2]);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (exp_hit != 16'hFFFF) exp_hit++;
    if (st) begin
      m_line[idx][16*w +: 16] = wd;
      m_dirty[idx] = 1'b1;
    end else begin
      check_val("rdata", {48'd0, rd}, {48'd0, m_line[idx][16*w +: 16]});
    end

    @(posedge clk);
    #1;
    check_val("hit_cnt",  {48'd0, hit_cnt},  {48'd0, exp_hit});
    check_val("miss_cnt", {48'd0, miss_cnt}, {48'd0, exp_miss});
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
  endtask

  // Cycles with no request; stray mem_rdy pulses must be ignored.
  task automatic idle(input int n);
    logic [2:0] idx;
    for (int i = 0; i < n; i++) begin
      bus.cpu_addr = 16'($urandom_range(0, 127));
      idx = bus.cpu_addr[4:2];
      @(negedge clk);
      bus.mem_rdy = ($urandom_range(0, 2) == 0);
      check_val("idle_stall", {63'd0, bus.stall}, 64'd0);
      check_val("idle_mem", {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
      if (!m_valid[idx]) check_val("rdata_inv", {48'd0, bus.cpu_rdata}, 64'd0);
      @(posedge clk);
      #1;
      bus.mem_rdy = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    bit          wb;
    logic [15:0] a;

    rst_n         = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = 16'h0000;
    bus.mem_rdata = 64'd0;
    bus.mem_rdy   = 1'b0;
    model_reset();

    #12;
    check_val("rst_mem_re",    {63'd0, bus.mem_re}, 64'd0);
    check_val("rst_mem_we",    {63'd0, bus.mem_we}, 64'd0);
    check_val("rst_mem_addr",  {50'd0, bus.mem_addr}, 64'd0);
    check_val("rst_mem_wdata", bus.mem_wdata, 64'd0);
    check_val("rst_hit_cnt",   {48'd0, hit_cnt}, 64'd0);
    check_val("rst_miss_cnt",  {48'd0, miss_cnt}, 64'd0);
    check_val("rst_stall",     {63'd0, bus.stall}, 64'd0);
    check_val("rst_rdata",     {48'd0, bus.cpu_rdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed: clean miss, hits, store hit, dirty-victim miss
    main_mem[14'h004] = 64'h4444_3333_2222_1111;
    do_req(16'h0010, 1'b0, 16'h0000, 0, 3, rd, wb);
    check_val("dir_rd_0010", {48'd0, rd}, 64'h1111);
    check_val("dir_miss1", {48'd0, miss_cnt}, 64'd1);
    check_val("dir_hit1",  {48'd0, hit_cnt},  64'd1);
    do_req(16'h0013, 1'b0, 16'h0000, 0, 0, rd, wb);
    check_val("dir_rd_0013", {48'd0, rd}, 64'h4444);
    do_req(16'h0011, 1'b1, 16'hBEEF, 0, 0, rd, wb);
    do_req(16'h0011, 1'b0, 16'h0000, 0, 0, rd, wb);
    check_val("dir_rd_0011", {48'd0, rd}, 64'hBEEF);
    do_req(16'h0030, 1'b0, 16'h0000, 2, 2, rd, wb);
    check_val("dir_wb_0030", {63'd0, wb}, 64'd1);
    check_val("dir_wb_mem", main_mem[14'h004], 64'h4444_3333_BEEF_1111);
    check_val("dir_miss2", {48'd0, miss_cnt}, 64'd2);
    idle(3);

    // reset while a fill is outstanding
    bus.cpu_addr = 16'h0050;
    bus.cpu_re   = 1'b1;
    bus.cpu_we   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("alloc_mem_re", {63'd0, bus.mem_re}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_mem_re",   {63'd0, bus.mem_re}, 64'd0);
    check_val("midrst_mem_we",   {63'd0, bus.mem_we}, 64'd0);
    check_val("midrst_mem_addr", {50'd0, bus.mem_addr}, 64'd0);
    check_val("midrst_miss_cnt", {48'd0, miss_cnt}, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_hold_re", {63'd0, bus.mem_re}, 64'd0);
    bus.cpu_re = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(16'h0010, 1'b0, 16'h0000, 0, 2, rd, wb);
    check_val("postrst_miss", {48'd0, miss_cnt}, 64'd1);

    // store miss to an invalid line, then a conflicting miss writes it back
    do_req(16'h0008, 1'b1, 16'h1234, 0, 2, rd, wb);
    check_val("st_inv_no_wb", {63'd0, wb}, 64'd0);
    do_req(16'h0028, 1'b0, 16'h0000, 3, 1, rd, wb);
    check_val("st_inv_later_wb", {63'd0, wb}, 64'd1);
    idle(2);

    // random traffic over a few tags so lines conflict and go dirty
    for (int i = 0; i < 300; i++) begin
      a = {11'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_req(a, 1'($urandom_range(0, 1)), 16'($urandom), 0, 0, rd, wb);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
